// File: rtl/poly_tone_pkg.sv
// Shared types and constants for the polyphonic tone generator.
package poly_tone_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    NOTE_ON  = 2'd0,
    NOTE_OFF = 2'd1,
    ALL_OFF  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  // Command FSM: IDLE accepts commands, SWEEP silences one channel per cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Speaker mixer selection.
  localparam int MIX_XOR = 0;
  localparam int MIX_PWM = 1;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: half-period counter, phase bit, pending period and
// click-free release. A channel only ever stops on a low phase.
module tone_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_req,     // accepted NOTE_ON with non-zero period
  input  logic             off_req,    // accepted NOTE_OFF (or NOTE_ON with zero period)
  input  logic             force_off,  // sweep silences this channel now
  input  logic [CNT_W-1:0] on_period,
  output logic             active,
  output logic             phase
);

  logic             active_q;
  logic             phase_q;
  logic             pend_valid_q;
  logic             rel_pend_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] pend_period_q;

  logic toggle;
  logic off_now;
  logic rel_now;
  logic clear;

  // The phase flips at the end of the last cycle of each half-period.
  assign toggle  = active_q && (count_q == period_q - CNT_W'(1));
  // Stop at once when low, or when the high half ends in this very cycle.
  assign off_now = off_req && (!phase_q || toggle);
  // A deferred release completes as the phase falls back to 0; a fresh
  // NOTE_ON in the same cycle cancels it.
  assign rel_now = rel_pend_q && toggle && !on_req;
  assign clear   = reset || force_off || (active_q && (off_now || rel_now));

  assign active = active_q;
  assign phase  = phase_q;

  // Channel state update: start, run, retune at toggle boundaries, release.
  always_ff @(posedge clk) begin
    if (clear) begin
      active_q      <= 1'b0;
      phase_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      rel_pend_q    <= 1'b0;
      count_q       <= '0;
      period_q      <= '0;
      pend_period_q <= '0;
    end else if (!active_q) begin
      if (on_req) begin
        active_q <= 1'b1;
        period_q <= on_period;
      end
    end else begin
      if (toggle) begin
        count_q <= '0;
        phase_q <= !phase_q;
        if (pend_valid_q) begin
          period_q <= pend_period_q;
        end
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
      if (on_req) begin
        pend_period_q <= on_period;
        pend_valid_q  <= 1'b1;
        rel_pend_q    <= 1'b0;
      end else begin
        if (toggle) begin
          pend_valid_q <= 1'b0;
        end
        if (off_req) begin
          rel_pend_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator: command handshake, ALL_OFF sweep
// FSM, NUM_CH tone channels and a registered XOR or PWM-sum speaker mixer.
module poly_tone_gen
  import poly_tone_pkg::*;
#(
  parameter int NUM_CH   = 13,
  parameter int CNT_W    = 32,
  parameter int MIX_MODE = MIX_PWM
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic [CNT_W-1:0]          cmd_half_period,
  output logic [NUM_CH-1:0]         ch_active,
  output logic                      spkr,
  output sweep_state_e              dbg_state
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LVL_W = $clog2(NUM_CH + 1);

  sweep_state_e      state_q, state_d;
  logic [CH_W-1:0]   sweep_idx_q, sweep_idx_d;
  cmd_op_e           op;
  logic              cmd_fire;
  logic              note_on;
  logic              note_off;
  logic [NUM_CH-1:0] phase_vec;
  logic [NUM_CH-1:0] force_vec;

  // Handshake: a command transfers on any rising clk edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is high only in IDLE with reset
  // low, so at most one command moves per cycle and none during a sweep.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op        = cmd_op_e'(cmd_op);
  assign note_on   = cmd_fire && (op == NOTE_ON) && (cmd_half_period != '0);
  assign note_off  = cmd_fire && ((op == NOTE_OFF) ||
                                  ((op == NOTE_ON) && (cmd_half_period == '0)));
  assign dbg_state = state_q;

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // Sweep FSM next state: ALL_OFF walks channel 0..NUM_CH-1, one per cycle.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire && (op == ALL_OFF)) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
        end
      end
      SWEEP: begin
        if (sweep_idx_q == CH_W'(NUM_CH - 1)) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel bank; out-of-range cmd_ch matches no channel and is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel          = (cmd_ch == CH_W'(i));
    assign force_vec[i] = (state_q == SWEEP) && (sweep_idx_q == CH_W'(i));

    tone_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .on_req    (note_on && sel),
      .off_req   (note_off && sel),
      .force_off (force_vec[i]),
      .on_period (cmd_half_period),
      .active    (ch_active[i]),
      .phase     (phase_vec[i])
    );
  end

  if (MIX_MODE == MIX_XOR) begin : g_xor
    // XOR mixer: parity of all phase bits, one cycle late.
    always_ff @(posedge clk) begin
      if (reset) begin
        spkr <= 1'b0;
      end else begin
        spkr <= ^phase_vec;
      end
    end
  end else begin : g_pwm
    logic [LVL_W-1:0] pop;
    logic [CH_W-1:0]  frame_q;
    logic [LVL_W-1:0] level_q;

    // Number of channels currently in their high half.
    always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pop = pop + LVL_W'(phase_vec[i]);
      end
    end

    // PWM mixer: level latched on frame slot 0, high for the first level slots.
    always_ff @(posedge clk) begin
      if (reset) begin
        frame_q <= '0;
        level_q <= '0;
        spkr    <= 1'b0;
      end else begin
        frame_q <= (frame_q == CH_W'(NUM_CH - 1)) ? '0 : frame_q + CH_W'(1);
        if (frame_q == '0) begin
          level_q <= pop;
          spkr    <= (pop != '0);
        end else begin
          spkr <= (LVL_W'(frame_q) < level_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: an XOR-mix and a PWM-mix instance share one
// command stream; a timeline model predicts every output each cycle.
module tb_poly_tone_gen;
  import poly_tone_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_ch = 2'd0;
  logic [7:0] cmd_half_period = 8'd0;
  logic ready0, ready1, spk0, spk1;
  logic [N-1:0] act0, act1;
  sweep_state_e dbg0, dbg1;

  always #5 clk = ~clk;

  poly_tone_gen #(.NUM_CH(N), .CNT_W(8), .MIX_MODE(MIX_XOR)) u_xor (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready0),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_half_period(cmd_half_period),
    .ch_active(act0), .spkr(spk0), .dbg_state(dbg0));

  poly_tone_gen #(.NUM_CH(N), .CNT_W(8), .MIX_MODE(MIX_PWM)) u_pwm (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_half_period(cmd_half_period),
    .ch_active(act1), .spkr(spk1), .dbg_state(dbg1));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // Each sounding channel is described by absolute cycle numbers: the cycle
  // at whose end its next toggle falls, and its current half-period.
  int m_act[N], m_ph[N], m_nt[N], m_per[N], m_pend[N], m_rel[N];
  int m_cyc = 0, m_fr = 0, m_lvl = 0, m_sw_idx = 0;
  bit m_sw = 0, m_acc = 0, e_s0 = 0, e_s1 = 0;

  function automatic void ch_clear(int i);
    m_act[i] = 0; m_ph[i] = 0; m_nt[i] = 0; m_per[i] = 0; m_pend[i] = -1; m_rel[i] = 0;
  endfunction

  always @(posedge clk) begin
    int pc, px, p;
    bit acc, on, off, tog, frc;
    m_acc = 0;
    if (reset) begin
      for (int i = 0; i < N; i++) ch_clear(i);
      m_fr = 0; m_lvl = 0; m_sw = 0; m_sw_idx = 0; e_s0 = 0; e_s1 = 0;
    end else begin
      pc = 0; px = 0;
      for (int i = 0; i < N; i++) begin pc += m_ph[i]; px ^= m_ph[i]; end
      e_s0 = px[0];
      if (m_fr == 0) m_lvl = pc;
      e_s1 = (m_fr < m_lvl);
      m_fr = (m_fr + 1) % N;
      acc = cmd_valid && !m_sw;
      m_acc = acc;
      p = int'(cmd_half_period);
      for (int i = 0; i < N; i++) begin
        on  = acc && cmd_op == 2'd0 && int'(cmd_ch) == i && p != 0;
        off = acc && int'(cmd_ch) == i && (cmd_op == 2'd1 || (cmd_op == 2'd0 && p == 0));
        frc = m_sw && m_sw_idx == i;
        tog = m_act[i] != 0 && m_cyc == m_nt[i];
        if (frc) ch_clear(i);
        else if (m_act[i] == 0) begin
          if (on) begin m_act[i] = 1; m_per[i] = p; m_nt[i] = m_cyc + p; end
        end else if (off && (m_ph[i] == 0 || tog)) ch_clear(i);
        else if (m_rel[i] != 0 && tog && !on) ch_clear(i);
        else begin
          if (tog) begin
            m_ph[i] ^= 1;
            if (m_pend[i] >= 0) m_per[i] = m_pend[i];
            m_nt[i] = m_cyc + m_per[i];
          end
          if (on) begin m_pend[i] = p; m_rel[i] = 0; end
          else begin
            if (tog) m_pend[i] = -1;
            if (off) m_rel[i] = 1;
          end
        end
      end
      if (m_sw) begin
        if (m_sw_idx == N - 1) m_sw = 0;
        m_sw_idx++;
      end else if (acc && cmd_op == 2'd2) begin
        m_sw = 1; m_sw_idx = 0;
      end
    end
    m_cyc++;
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    logic [N-1:0] ea;
    if (chk_en) begin
      for (int i = 0; i < N; i++) ea[i] = (m_act[i] != 0);
      chk("ready_xor", ready0, !reset && !m_sw);
      chk("ready_pwm", ready1, !reset && !m_sw);
      chk("active_xor", act0, ea);
      chk("active_pwm", act1, ea);
      chk("spkr_xor", spk0, e_s0);
      chk("spkr_pwm", spk1, e_s1);
      chk("sweep_state", dbg0 == SWEEP, m_sw);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input int ch, input int p);
    cmd_op = op; cmd_ch = 2'(ch); cmd_half_period = 8'(p); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic count_hi(input int sel, input int cycles, output int hits);
    hits = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (((sel == 0) ? spk0 : spk1) === 1'b1) hits++;
    end
  endtask

  // Length of the current run of spk0 at level lvl (sampled after edges).
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (spk0 !== lvl) break;
      n++;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rise, hi, lo, hits, r;
    logic [N-1:0] sw_act[5];
    logic sw_rdy[5];
    sw_act[0] = 4'b1111; sw_act[1] = 4'b1110; sw_act[2] = 4'b1100;
    sw_act[3] = 4'b1000; sw_act[4] = 4'b0000;
    sw_rdy[0] = 0; sw_rdy[1] = 0; sw_rdy[2] = 0; sw_rdy[3] = 0; sw_rdy[4] = 1;

    // Reset state.
    tick(); chk_en = 1'b1; tick();
    chk("rst_active", act0, 0);
    chk("rst_ready", ready0, 0);
    chk("rst_spkr", spk1, 0);
    reset = 1'b0; #1;
    chk("rst_release_ready", ready0, 1);

    // Single tone P=5: rise 6 edges after accept, 5 high / 5 low.
    send(NOTE_ON, 0, 5);
    rise = -1;
    for (int k = 1; k <= 30; k++) begin
      if (spk0 === 1'b1) begin rise = k - 1; break; end
      tick();
    end
    chk("tone_first_rise", rise, 6);
    run_len(1'b1, hi); chk("tone_high_len", hi, 5);
    run_len(1'b0, lo); chk("tone_low_len", lo, 5);

    // Retune mid half-cycle: current half stays 4, then halves of 2.
    do_reset();
    send(NOTE_ON, 1, 4);
    send(NOTE_ON, 1, 2);
    rise = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (spk0 === 1'b1) begin rise = k; break; end
    end
    chk("retune_rise", rise, 4);
    run_len(1'b1, hi); chk("retune_high_len", hi, 2);
    run_len(1'b0, lo); chk("retune_low_len", lo, 2);

    // Release while high: channel waits for the falling edge.
    do_reset();
    send(NOTE_ON, 0, 3);
    repeat (3) tick();
    send(NOTE_OFF, 0, 0);
    chk("release_hold0", act0[0], 1);
    hits = (spk0 === 1'b1) ? 1 : 0;
    tick(); chk("release_hold1", act0[0], 1);
    if (spk0 === 1'b1) hits++;
    tick(); chk("release_done", act0[0], 0);
    if (spk0 === 1'b1) hits++;
    count_hi(0, 8, r);
    chk("release_pulse_len", hits + r, 3);

    // ALL_OFF sweep with all four channels sounding.
    do_reset();
    for (int c = 0; c < N; c++) send(NOTE_ON, c, 3 + c);
    repeat (5) tick();
    send(ALL_OFF, 0, 0);
    for (int j = 0; j < 5; j++) begin
      chk("sweep_active_seq", act0, sw_act[j]);
      chk("sweep_ready_seq", ready0, sw_rdy[j]);
      tick();
    end
    repeat (8) tick();
    chk("sweep_quiet_xor", spk0, 0);
    chk("sweep_quiet_pwm", spk1, 0);

    // PWM mix: two of four high -> half duty; all four high -> constant 1.
    do_reset();
    send(NOTE_ON, 0, 60);
    send(NOTE_ON, 1, 60);
    repeat (70) tick();
    count_hi(1, 8, hits);
    chk("pwm_two_of_four", hits, 4);
    do_reset();
    for (int c = 0; c < N; c++) send(NOTE_ON, c, 40);
    repeat (50) tick();
    count_hi(1, 16, hits);
    chk("pwm_all_high", hits, 16);

    // Reset in the middle of a sweep with tones running.
    do_reset();
    for (int c = 0; c < N; c++) send(NOTE_ON, c, 3 + c);
    repeat (10) tick();
    send(ALL_OFF, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midsweep_rst_active", act1, 0);
    chk("midsweep_rst_spkr_xor", spk0, 0);
    chk("midsweep_rst_spkr_pwm", spk1, 0);
    chk("midsweep_rst_ready", ready0, 0);
    reset = 1'b0; #1;
    chk("midsweep_release_ready", ready0, 1);
    count_hi(0, 20, hits);
    chk("midsweep_no_residue", hits, 0);

    // Randomized traffic, valid held until accepted, occasional resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1; cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset = 1'b0;
      end else begin
        if (!cmd_valid || m_acc) begin
          cmd_valid = ($urandom_range(0, 2) == 0);
          r = $urandom_range(0, 19);
          cmd_op = (r < 10) ? 2'd0 : (r < 17) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
          cmd_ch = 2'($urandom_range(0, N - 1));
          cmd_half_period = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        end
        tick();
      end
    end
    cmd_valid = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/poly_tone_gen.md
POLY_TONE_GEN -- requirements
Module: poly_tone_gen

Interface
REQ-001 Parameter NUM_CH, default 13: number of independent tone channels (2..32).
REQ-002 Parameter CNT_W, default 32: width of half-period and channel counters.
REQ-003 Parameter MIX_MODE, default 1: 0 = XOR mix, 1 = PWM sum mix.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  input  2  0 NOTE_ON, 1 NOTE_OFF, 2 ALL_OFF, 3 reserved (accepted, no effect).
REQ-009 cmd_ch  input  clog2(NUM_CH)  target channel; ignored for ALL_OFF.
REQ-010 cmd_half_period  input  CNT_W  half-period in clk cycles; NOTE_ON only.
REQ-011 ch_active  output  NUM_CH  per-channel sounding flag.
REQ-012 spkr  output  1  mixed speaker output, registered.

Function
REQ-013 Per channel state: active, phase, count, period, pend_period, pend_valid, rel_pend.
REQ-014 Active channel each cycle: if count == period-1 then count<=0, phase toggles, else count+1; output half-period = period cycles.
REQ-015 NOTE_ON to inactive channel with P>0: next cycle active=1, count=0, phase=0, period=P; phase first rises P cycles after ch_active rises.
REQ-016 NOTE_ON to active channel: P stored in pend_period, pend_valid=1; loaded into period at next toggle (phase-continuous); a later NOTE_ON before that toggle overwrites pend_period.
REQ-017 NOTE_ON with P=0 behaves as NOTE_OFF.
REQ-018 NOTE_OFF to active channel: if phase=0, channel goes inactive next cycle; else rel_pend=1 and channel goes inactive on the cycle phase returns to 0 (click-free release); NOTE_ON arriving while rel_pend clears rel_pend and acts per REQ-016.
REQ-019 NOTE_OFF to inactive channel: no effect; cmd_ch >= NUM_CH: command accepted, no effect.
REQ-020 Inactive channel: phase=0, count=0, pend_valid=0, rel_pend=0.
REQ-021 ALL_OFF: FSM IDLE -> SWEEP; SWEEP forces one channel per cycle inactive, index 0 to NUM_CH-1, then returns to IDLE; cmd_ready=0 throughout SWEEP (NUM_CH cycles).
REQ-022 cmd_ready=1 in IDLE outside reset; at most one command accepted per cycle.
REQ-023 MIX_MODE=0: spkr <= XOR of all phase bits, one-cycle latency.
REQ-024 MIX_MODE=1: level = count of channels with phase=1, sampled at start of each NUM_CH-cycle PWM frame; spkr=1 for the first level cycles of the frame; level = NUM_CH gives constant 1.
REQ-025 All channels silent: spkr=0 in both modes.
REQ-026 Counters never exceed period-1; period change takes effect only at a toggle boundary, never mid-half-cycle.

Reset
REQ-027 While reset high: all channel state 0, FSM IDLE, PWM frame counter 0, spkr=0, ch_active=0, cmd_ready=0.
REQ-028 First cycle after reset deasserts: cmd_ready=1; reset mid-sweep or mid-tone aborts immediately with no residual toggles.

Structure
REQ-029 Shared package poly_tone_pkg holds cmd_op enum (NOTE_ON, NOTE_OFF, ALL_OFF), FSM state enum, and MIX_MODE constants.
REQ-030 One sub-module tone_channel (one instance per channel, generate loop) owns counter, phase, pending period and release logic; top owns handshake, sweep FSM and mixer.

Verification (NUM_CH=4, CNT_W=8 unless noted)
REQ-031 NOTE_ON ch0 P=5, MIX_MODE=0 -> ch_active[0] next cycle; spkr square wave, 5 high / 5 low, first rise 6 cycles after accept.
REQ-032 NOTE_ON ch1 P=4 then, mid-half-cycle, NOTE_ON ch1 P=2 -> current half-cycle completes at 4 cycles, subsequent half-cycles 2.
REQ-033 NOTE_OFF ch0 while phase=1 -> ch_active[0] stays 1 until phase falls, then 0; no truncated high pulse.
REQ-034 ch0..ch3 active, ALL_OFF -> cmd_ready low exactly 4 cycles, ch_active clears 1 bit/cycle 0..3, spkr 0 afterwards.
REQ-035 MIX_MODE=1, ch0 and ch1 phase=1, ch2/3 off -> spkr high 2 of 4 cycles per frame; all four high -> spkr constant 1.
REQ-036 Assert reset during SWEEP with tones active -> next cycle all outputs 0; cmd_ready 1 first cycle after release.
